// File: rtl/param_counter_pkg.sv
// Shared constants for the parameterised up/down counter: count direction
// encoding and bound-behaviour modes.
package param_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/param_counter_prescaler.sv
// Prescaler: emits a one-cycle step every PRESCALE enabled cycles.
// restart zeroes the phase; for PRESCALE=1 it is a plain wire from enable.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic step
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset ^ restart;
      assign step = enable;
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          phase <= '0;
        end else if (restart) begin
          phase <= '0;
        end else if (enable) begin
          phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
      end

      assign step = enable && (phase == LAST);
    end
  endgenerate

endmodule

// File: rtl/param_counter.sv
// Parameterised up/down counter with prescaler, wrap or saturate at the
// bound, a one-cycle wrap pulse and a sticky overflow flag.
module param_counter
  import param_counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE  = 1,
  parameter int              SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter_out,
  output logic             terminal,
  output logic             wrap_pulse,
  output logic             overflow_sticky
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  logic restart;
  logic step;
  logic count_step;
  logic crossed;
  logic [WIDTH-1:0] next_count;

  // Clamp a loaded value into the legal count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
    return (value > MAX_C) ? MAX_C : value;
  endfunction

  // One count step; MSB of the result flags a bound crossing.
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] cur,
                                                input logic             dir);
    logic             hit;
    logic [WIDTH-1:0] nxt;
    hit = 1'b0;
    if (dir == DIR_UP) begin
      if (cur == MAX_C) begin
        hit = 1'b1;
        nxt = (SATURATE == MODE_SAT) ? cur : '0;
      end else begin
        nxt = cur + WIDTH'(1);
      end
    end else begin
      if (cur == '0) begin
        hit = 1'b1;
        nxt = (SATURATE == MODE_SAT) ? cur : MAX_C;
      end else begin
        nxt = cur - WIDTH'(1);
      end
    end
    return {hit, nxt};
  endfunction

  assign restart    = clear | load;
  assign count_step = step & ~restart;
  assign {crossed, next_count} = step_count(counter_out, up_down);

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .restart (restart),
    .step    (step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_out     <= '0;
      wrap_pulse      <= 1'b0;
      overflow_sticky <= 1'b0;
    end else if (clear) begin
      counter_out     <= '0;
      wrap_pulse      <= 1'b0;
      overflow_sticky <= 1'b0;
    end else if (load) begin
      counter_out <= clamp_load(load_value);
      wrap_pulse  <= 1'b0;
    end else if (count_step) begin
      counter_out <= next_count;
      wrap_pulse  <= crossed && (SATURATE != MODE_SAT);
      if (crossed) begin
        overflow_sticky <= 1'b1;
      end
    end else begin
      wrap_pulse <= 1'b0;
    end
  end

  assign terminal = (up_down == DIR_UP) ? (counter_out == MAX_C)
                                        : (counter_out == '0);

endmodule
